// File: rtl/store_queue_pkg.sv
// Shared types and constants for the store queue: entry layout, drain states,
// and the word-granularity alias check used by the load hazard path.
package store_queue_pkg;

  localparam int PAGE_OFFSET_W   = 12;
  localparam int WORD_OFFSET_LSB = 3;
  localparam int SQ_ADDR_W       = 64;
  localparam int SQ_DATA_W       = 64;
  localparam int SQ_BE_W         = SQ_DATA_W / 8;

  typedef struct packed {
    logic [SQ_ADDR_W-1:0] paddr;
    logic [SQ_DATA_W-1:0] data;
    logic [SQ_BE_W-1:0]   be;
  } sq_entry_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_ACK = 2'd2
  } sq_state_t;

  // Two offsets alias when they fall in the same 8-byte word of the page.
  function automatic logic word_alias(input logic [PAGE_OFFSET_W-1:0] a,
                                      input logic [PAGE_OFFSET_W-1:0] b);
    return a[PAGE_OFFSET_W-1:WORD_OFFSET_LSB] == b[PAGE_OFFSET_W-1:WORD_OFFSET_LSB];
  endfunction

endpackage

// File: rtl/store_queue_if.sv
// Store queue bundle: LSU push/commit/flush side, load hazard query and the
// data memory write port. The queue itself is the slave end.
interface store_queue_if
  import store_queue_pkg::*;
#(
  parameter int ADDRESS_SIZE = 64,
  parameter int DATA_WIDTH   = 64
);
  logic                     flush;
  logic                     store_valid;
  logic [ADDRESS_SIZE-1:0]  store_paddr;
  logic [DATA_WIDTH-1:0]    store_data;
  logic [DATA_WIDTH/8-1:0]  store_be;
  logic                     ready;
  logic                     commit;
  logic                     commit_ready;
  logic [PAGE_OFFSET_W-1:0] page_offset;
  logic                     page_offset_matches;
  logic                     no_st_pending;
  logic                     mem_req;
  logic [ADDRESS_SIZE-1:0]  mem_addr;
  logic [DATA_WIDTH-1:0]    mem_wdata;
  logic [DATA_WIDTH/8-1:0]  mem_be;
  logic                     mem_gnt;
  logic                     mem_ack;

  modport slave (
    input  flush, store_valid, store_paddr, store_data, store_be, commit,
           page_offset, mem_gnt, mem_ack,
    output ready, commit_ready, page_offset_matches, no_st_pending,
           mem_req, mem_addr, mem_wdata, mem_be
  );

  modport master (
    output flush, store_valid, store_paddr, store_data, store_be, commit,
           page_offset, mem_gnt, mem_ack,
    input  ready, commit_ready, page_offset_matches, no_st_pending,
           mem_req, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/sq_drain_fsm.sv
// Memory write handshake: one outstanding write, pop strobe on ack.
module sq_drain_fsm
  import store_queue_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic pending_i,
  input  logic mem_gnt_i,
  input  logic mem_ack_i,
  output logic mem_req_o,
  output logic pop_o,
  output logic idle_o
);

  localparam logic [1:0] ST_IDLE     = 2'(IDLE);
  localparam logic [1:0] ST_REQ      = 2'(REQ);
  localparam logic [1:0] ST_WAIT_ACK = 2'(WAIT_ACK);

  logic [1:0] state_q;
  logic [1:0] state_d;

  // Next-state: ack arriving alongside gnt is ignored in REQ.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (pending_i) state_d = ST_REQ;     else state_d = ST_IDLE;
      ST_REQ:      if (mem_gnt_i) state_d = ST_WAIT_ACK; else state_d = ST_REQ;
      ST_WAIT_ACK: if (mem_ack_i) state_d = ST_IDLE;    else state_d = ST_WAIT_ACK;
      default:     state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  assign mem_req_o = (state_q == ST_REQ);
  assign pop_o     = (state_q == ST_WAIT_ACK) & mem_ack_i;
  assign idle_o    = (state_q == ST_IDLE);

endmodule

// File: rtl/store_queue.sv
// Store queue: circular buffer of speculative and committed stores, drained
// in order to data memory, with a page-offset alias check for loads.
module store_queue
  import store_queue_pkg::*;
#(
  parameter int ADDRESS_SIZE = 64,
  parameter int DATA_WIDTH   = 64,
  parameter int DEPTH        = 4
) (
  input logic          clk,
  input logic          rst,
  store_queue_if.slave sq
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] cm_ptr_q, cm_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] cm_cnt_q, cm_cnt_d;
  logic [CNT_W-1:0] sp_cnt_q, sp_cnt_d;
  sq_entry_t        entries_q [DEPTH];

  logic [CNT_W-1:0] total_s;
  logic             ready_s;
  logic             commit_ready_s;
  logic             push_s;
  logic             commit_s;
  logic             pop_s;
  logic             idle_s;
  logic             match_s;
  logic [PTR_W-1:0] off_s;
  sq_entry_t        new_entry_s;

  assign total_s        = cm_cnt_q + sp_cnt_q;
  assign ready_s        = total_s < CNT_W'(DEPTH);
  assign commit_ready_s = sp_cnt_q != '0;
  assign push_s         = sq.store_valid & ready_s & ~sq.flush;
  assign commit_s       = sq.commit & commit_ready_s;

  assign new_entry_s.paddr = SQ_ADDR_W'(sq.store_paddr);
  assign new_entry_s.data  = SQ_DATA_W'(sq.store_data);
  assign new_entry_s.be    = SQ_BE_W'(sq.store_be);

  // Counters move by the net effect of push, commit, flush and pop together.
  always_comb begin
    cm_ptr_d = cm_ptr_q + PTR_W'(commit_s);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_s);
    cm_cnt_d = cm_cnt_q + CNT_W'(commit_s) - CNT_W'(pop_s);
    if (sq.flush) begin
      wr_ptr_d = cm_ptr_d;
      sp_cnt_d = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + PTR_W'(push_s);
      sp_cnt_d = sp_cnt_q + CNT_W'(push_s) - CNT_W'(commit_s);
    end
  end

  // Pointer and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      cm_ptr_q <= '0;
      wr_ptr_q <= '0;
      cm_cnt_q <= '0;
      sp_cnt_q <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      cm_ptr_q <= cm_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cm_cnt_q <= cm_cnt_d;
      sp_cnt_q <= sp_cnt_d;
    end
  end

  // Entry storage; contents are only meaningful inside the valid window.
  always_ff @(posedge clk) begin
    if (push_s) entries_q[wr_ptr_q] <= new_entry_s;
  end

  // Valid window is the total count starting at rd_ptr, in-flight entry included.
  always_comb begin
    match_s = 1'b0;
    off_s   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off_s   = PTR_W'(i) - rd_ptr_q;
      match_s = match_s | (({1'b0, off_s} < total_s) &
                word_alias(entries_q[i].paddr[PAGE_OFFSET_W-1:0], sq.page_offset));
    end
  end

  sq_drain_fsm u_drain (
    .clk       (clk),
    .rst       (rst),
    .pending_i (cm_cnt_q != '0),
    .mem_gnt_i (sq.mem_gnt),
    .mem_ack_i (sq.mem_ack),
    .mem_req_o (sq.mem_req),
    .pop_o     (pop_s),
    .idle_o    (idle_s)
  );

  assign sq.ready               = ready_s;
  assign sq.commit_ready        = commit_ready_s;
  assign sq.page_offset_matches = match_s;
  assign sq.no_st_pending       = (cm_cnt_q == '0) & (sp_cnt_q == '0) & idle_s;
  assign sq.mem_addr            = ADDRESS_SIZE'(entries_q[rd_ptr_q].paddr);
  assign sq.mem_wdata           = DATA_WIDTH'(entries_q[rd_ptr_q].data);
  assign sq.mem_be              = (DATA_WIDTH/8)'(entries_q[rd_ptr_q].be);

endmodule

// File: tb/tb_store_queue.sv
// Self-checking bench for store_queue: queue-based reference model checked
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_store_queue;
  import store_queue_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  store_queue_if #(.ADDRESS_SIZE(64), .DATA_WIDTH(64)) sq_if ();

  store_queue #(.ADDRESS_SIZE(64), .DATA_WIDTH(64), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .sq  (sq_if)
  );

  typedef struct {
    logic [63:0] paddr;
    logic [63:0] data;
    logic [7:0]  be;
  } ent_t;

  ent_t spec_q[$];
  ent_t comm_q[$];
  int   phase;  // memory port: 0 idle, 1 requesting, 2 awaiting ack
  int   checks   = 0;
  int   failures = 0;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic model_match(input logic [11:0] po);
    foreach (comm_q[i]) if (comm_q[i].paddr[11:3] == po[11:3]) return 1'b1;
    foreach (spec_q[i]) if (spec_q[i].paddr[11:3] == po[11:3]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    spec_q.delete();
    comm_q.delete();
    phase = 0;
  endtask

  task automatic check_outputs();
    int n;
    n = spec_q.size() + comm_q.size();
    cmp("ready", sq_if.ready, n < DEPTH);
    cmp("commit_ready", sq_if.commit_ready, spec_q.size() != 0);
    cmp("no_st_pending", sq_if.no_st_pending, (n == 0) && (phase == 0));
    cmp("mem_req", sq_if.mem_req, phase == 1);
    if (phase == 1 && comm_q.size() != 0) begin
      cmp("mem_addr", sq_if.mem_addr, comm_q[0].paddr);
      cmp("mem_wdata", sq_if.mem_wdata, comm_q[0].data);
      cmp("mem_be", sq_if.mem_be, comm_q[0].be);
    end
    cmp("page_offset_matches", sq_if.page_offset_matches, model_match(sq_if.page_offset));
  endtask

  task automatic model_edge();
    int   n;
    bit   cfire, push, pop;
    ent_t e;
    if (rst) begin
      model_reset();
      return;
    end
    n     = spec_q.size() + comm_q.size();
    cfire = sq_if.commit && spec_q.size() != 0;
    push  = sq_if.store_valid && n < DEPTH && !sq_if.flush;
    pop   = phase == 2 && sq_if.mem_ack;
    case (phase)
      0:       if (comm_q.size() != 0) phase = 1;
      1:       if (sq_if.mem_gnt) phase = 2;
      default: if (sq_if.mem_ack) phase = 0;
    endcase
    if (pop) void'(comm_q.pop_front());
    if (cfire) comm_q.push_back(spec_q.pop_front());
    if (sq_if.flush) spec_q.delete();
    if (push) begin
      e.paddr = sq_if.store_paddr;
      e.data  = sq_if.store_data;
      e.be    = sq_if.store_be;
      spec_q.push_back(e);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic clear_in();
    sq_if.flush       = 1'b0;
    sq_if.store_valid = 1'b0;
    sq_if.store_paddr = 64'h0;
    sq_if.store_data  = 64'h0;
    sq_if.store_be    = 8'h0;
    sq_if.commit      = 1'b0;
    sq_if.mem_gnt     = 1'b0;
    sq_if.mem_ack     = 1'b0;
  endtask

  task automatic push(input logic [63:0] a, input logic [63:0] d, input logic [7:0] b);
    sq_if.store_valid = 1'b1;
    sq_if.store_paddr = a;
    sq_if.store_data  = d;
    sq_if.store_be    = b;
    tick();
    sq_if.store_valid = 1'b0;
  endtask

  task automatic do_commit();
    sq_if.commit = 1'b1;
    tick();
    sq_if.commit = 1'b0;
  endtask

  task automatic wait_req();
    int k;
    k = 0;
    while (!sq_if.mem_req && k < 20) begin
      tick();
      k++;
    end
    cmp("mem_req_timeout", sq_if.mem_req, 1'b1);
  endtask

  task automatic drain_one(input string name, input logic [63:0] exp_addr);
    wait_req();
    cmp(name, sq_if.mem_addr, exp_addr);
    sq_if.mem_gnt = 1'b1;
    tick();
    sq_if.mem_gnt = 1'b0;
    sq_if.mem_ack = 1'b1;
    tick();
    sq_if.mem_ack = 1'b0;
  endtask

  initial begin
    logic [63:0] a;
    rst = 1'b1;
    clear_in();
    sq_if.page_offset = 12'h0;
    model_reset();
    tick();
    tick();
    cmp("rst_ready", sq_if.ready, 1'b1);
    cmp("rst_commit_ready", sq_if.commit_ready, 1'b0);
    cmp("rst_no_st_pending", sq_if.no_st_pending, 1'b1);
    cmp("rst_mem_req", sq_if.mem_req, 1'b0);
    cmp("rst_matches", sq_if.page_offset_matches, 1'b0);
    rst = 1'b0;

    // Single store through the whole lifecycle.
    push(64'h1008, 64'hAA, 8'hFF);
    cmp("a_commit_ready", sq_if.commit_ready, 1'b1);
    cmp("a_no_st_pending", sq_if.no_st_pending, 1'b0);
    cmp("a_mem_req_early", sq_if.mem_req, 1'b0);
    do_commit();
    cmp("a_mem_req_idle", sq_if.mem_req, 1'b0);
    tick();
    cmp("a_mem_req", sq_if.mem_req, 1'b1);
    cmp("a_mem_addr", sq_if.mem_addr, 64'h1008);
    sq_if.mem_gnt = 1'b1;
    tick();
    sq_if.mem_gnt = 1'b0;
    cmp("a_req_drop", sq_if.mem_req, 1'b0);
    tick();
    sq_if.mem_ack = 1'b1;
    tick();
    sq_if.mem_ack = 1'b0;
    cmp("a_no_st_pending_end", sq_if.no_st_pending, 1'b1);

    // Full queue.
    for (int i = 1; i <= 4; i++) push(64'(i * 16), 64'(i), 8'h0F);
    cmp("full_ready", sq_if.ready, 1'b0);
    push(64'h50, 64'h5, 8'h01);
    cmp("full_model_spec", spec_q.size(), 4);
    do_commit();
    drain_one("full_drain_addr", 64'h10);
    cmp("ready_after_ack", sq_if.ready, 1'b1);
    sq_if.flush = 1'b1;
    tick();
    sq_if.flush = 1'b0;
    cmp("flush_empty", sq_if.no_st_pending, 1'b1);

    // Flush together with a commit keeps both committed entries.
    push(64'h1, 64'h11, 8'h01);
    push(64'h2, 64'h22, 8'h02);
    push(64'h3, 64'h33, 8'h04);
    do_commit();
    sq_if.commit = 1'b1;
    sq_if.flush  = 1'b1;
    tick();
    clear_in();
    cmp("fc_commit_ready", sq_if.commit_ready, 1'b0);
    cmp("fc_model_comm", comm_q.size(), 2);
    drain_one("fc_drain1", 64'h1);
    drain_one("fc_drain2", 64'h2);
    cmp("fc_no_st_pending", sq_if.no_st_pending, 1'b1);

    // Store in the flush cycle is dropped.
    sq_if.flush = 1'b1;
    push(64'h77, 64'h77, 8'hFF);
    sq_if.flush = 1'b0;
    cmp("fs_commit_ready", sq_if.commit_ready, 1'b0);
    cmp("fs_no_st_pending", sq_if.no_st_pending, 1'b1);

    // Page-offset alias across the entry's lifetime.
    sq_if.page_offset = 12'hAB8;
    push(64'h2ABC, 64'hBEEF, 8'hF0);
    cmp("po_match", sq_if.page_offset_matches, 1'b1);
    sq_if.page_offset = 12'hAC0;
    #1;
    cmp("po_nomatch", sq_if.page_offset_matches, 1'b0);
    sq_if.page_offset = 12'hAB8;
    do_commit();
    wait_req();
    sq_if.mem_gnt = 1'b1;
    tick();
    sq_if.mem_gnt = 1'b0;
    cmp("po_match_wait_ack", sq_if.page_offset_matches, 1'b1);
    sq_if.mem_ack = 1'b1;
    tick();
    sq_if.mem_ack = 1'b0;
    cmp("po_match_cleared", sq_if.page_offset_matches, 1'b0);

    // Asynchronous reset during an outstanding write.
    push(64'h100, 64'h1, 8'hFF);
    push(64'h200, 64'h2, 8'hFF);
    do_commit();
    do_commit();
    wait_req();
    sq_if.mem_gnt = 1'b1;
    tick();
    sq_if.mem_gnt = 1'b0;
    sq_if.page_offset = 12'h100;
    #1;
    cmp("pre_rst_match", sq_if.page_offset_matches, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    cmp("arst_ready", sq_if.ready, 1'b1);
    cmp("arst_commit_ready", sq_if.commit_ready, 1'b0);
    cmp("arst_no_st_pending", sq_if.no_st_pending, 1'b1);
    cmp("arst_mem_req", sq_if.mem_req, 1'b0);
    cmp("arst_matches", sq_if.page_offset_matches, 1'b0);
    model_reset();
    tick();
    rst = 1'b0;

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      a = {$urandom, $urandom};
      a[11:3] = 9'($urandom_range(0, 7));
      sq_if.store_valid = ($urandom_range(0, 99) < 55);
      sq_if.store_paddr = a;
      sq_if.store_data  = {$urandom, $urandom};
      sq_if.store_be    = 8'($urandom);
      sq_if.commit      = ($urandom_range(0, 99) < 35);
      sq_if.flush       = ($urandom_range(0, 99) < 5);
      sq_if.mem_gnt     = ($urandom_range(0, 99) < 50);
      sq_if.mem_ack     = ($urandom_range(0, 99) < 40);
      sq_if.page_offset = {3'($urandom), 6'($urandom_range(0, 7)), 3'($urandom)};
      sq_if.page_offset[11:9] = 3'($urandom_range(0, 1) == 1 ? a[11:9] : 3'($urandom));
      tick();
    end
    clear_in();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
